glitch_sweep: RTL and testbench
===============================

// Module: glitch_sweep
// PURPOSE
//  Sweeps glitch parameters for the glitch engine. It writes one schedule per attempt into the engine's 32-bit command FIFO.
//  Each schedule is one {delay,width,mode} command followed by null padding words, so the FIFO fills and triggers the engine.
//  It then tracks the engine's ready line and advances the point (width inner loop, delay outer loop) with REPEATS attempts per point.
//  Sits between the host config registers and the FIFO feeding the glitch engine.
// PARAMETERS
//  FIFO_DEPTH   4       words written per attempt; must equal command FIFO depth (>=1)
//  ARM_TIMEOUT  65535   cycles to wait for engine to leave idle after fill before error
// PORTS
//  clk_in       in   1   clock
//  rst          in   1   reset, synchronous, active-high
//  start        in   1   1-cycle pulse; latches cfg_* and begins sweep (ignored when busy)
//  abort        in   1   stop sweep, return to IDLE
//  cfg_dly_lo   in   16  first delay
//  cfg_dly_hi   in   16  last delay (inclusive)
//  cfg_dly_step in   16  delay increment (0 treated as 1)
//  cfg_wid_lo   in   8   first width
//  cfg_wid_hi   in   8   last width (inclusive)
//  cfg_wid_step in   8   width increment (0 treated as 1)
//  cfg_mode     in   8   mode byte placed in every word
//  cfg_repeats  in   8   attempts per point (0 treated as 1)
//  fifo_full    in   1   command FIFO full
//  glitch_ready in   1   engine idle flag
//  fifo_we      out  1   FIFO write strobe
//  fifo_din     out  32  FIFO write data {delay[31:16],width[15:8],mode[7:0]}
//  fifo_clr     out  1   1-cycle FIFO flush request
//  busy         out  1   high in any state but IDLE
//  done         out  1   1-cycle pulse on sweep completion
//  err          out  1   sticky error; cleared by accepted start or rst
//  cur_delay    out  16  delay of current point
//  cur_width    out  8   width of current point
//  attempt_cnt  out  32  completed attempts since last start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal counters 0; config regs 0.
//  States: IDLE, FILL, ARM, RUN, NEXT.
//  IDLE: start=1 with dly_lo<=dly_hi and wid_lo<=wid_hi:
//   - latch cfg; cur_delay=dly_lo, cur_width=wid_lo; clear attempt_cnt, err, rep_cnt, word_cnt.
//   - go to FILL; busy is 1 the next cycle.
//  IDLE: start=1 with invalid range: err=1, done pulses next cycle, stay IDLE.
//  FILL: each cycle fifo_full=0 -> fifo_we=1 and word_cnt++.
//   - word 0 = {cur_delay,cur_width,cfg_mode}; words 1..FIFO_DEPTH-1 = {16'h0,8'h0,cfg_mode}.
//   - fifo_full=1 -> fifo_we=0, wait.
//   - after FIFO_DEPTH writes go to ARM with tmo_cnt=0.
//   - fifo_din is registered with fifo_we; first write is 1 cycle after FILL entry.
//  ARM: glitch_ready=0 -> RUN.
//   - tmo_cnt reaches ARM_TIMEOUT -> err=1, fifo_clr pulse, IDLE, no done.
//  RUN: glitch_ready=1 -> attempt_cnt++ (wraps at 2^32), go to NEXT.
//  NEXT (1 cycle):
//   - rep_cnt+1 < repeats -> rep_cnt++, FILL.
//   - else rep_cnt=0; next width computed 9-bit: w+step > wid_hi (or carry) -> width=wid_lo and delay advances.
//   - next delay computed 17-bit: d+step > dly_hi (or carry) -> done pulse, IDLE; cur_* keep last point.
//   - otherwise -> FILL.
//  abort (any non-IDLE state, priority over all transitions): next cycle IDLE, fifo_we=0, fifo_clr pulse 1 cycle, no done, err unchanged.
//  start while busy: ignored. start and abort same cycle in IDLE: abort wins, start ignored.
//  rst mid-sweep: immediate return to reset values; no fifo_clr issued.
// TESTING
//  T1 dly 10..30 step 10, wid 2..2, rep 1, DEPTH 4; model engine -> 3 attempts, words 0x000A0205/0x00140205/0x001E0205 + pads, done, attempt_cnt=3.
//  T2 wid 1..5 step 2, dly 0..0, rep 2 -> widths 1,1,3,3,5,5; attempt_cnt=6; done one cycle.
//  T3 hold fifo_full=1 for 5 cycles mid-FILL -> no fifo_we while full; exactly 4 writes per attempt.
//  T4 glitch_ready stuck 1, ARM_TIMEOUT=8 -> err=1 and fifo_clr pulse after 8 ARM cycles; busy=0, done=0.
//  T5 abort during RUN -> IDLE next cycle, fifo_clr=1 for 1 cycle; restart then clears err and attempt_cnt.
//  T6 dly_hi=16'hFFFF step 16'h8000 from 16'h8000; start with wid_lo>wid_hi -> carry ends sweep after 2 points; invalid start gives err+done, busy=0.

Source files
------------

// File: rtl/glitch_sweep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : glitch_sweep                                                   |
// | Brief   : Sweeps delay/width points, loading one schedule per attempt    |
// |           into the glitch engine command FIFO.                           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module glitch_sweep #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ARM_TIMEOUT = 65535
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_dly_lo,
  input  logic [15:0] cfg_dly_hi,
  input  logic [15:0] cfg_dly_step,
  input  logic [7:0]  cfg_wid_lo,
  input  logic [7:0]  cfg_wid_hi,
  input  logic [7:0]  cfg_wid_step,
  input  logic [7:0]  cfg_mode,
  input  logic [7:0]  cfg_repeats,
  input  logic        fifo_full,
  input  logic        glitch_ready,
  output logic        fifo_we,
  output logic [31:0] fifo_din,
  output logic        fifo_clr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cur_delay,
  output logic [7:0]  cur_width,
  output logic [31:0] attempt_cnt
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_fill = 3'd1;
  localparam logic [2:0] c_st_arm  = 3'd2;
  localparam logic [2:0] c_st_run  = 3'd3;
  localparam logic [2:0] c_st_next = 3'd4;

  localparam logic [31:0] c_last_word = 32'(FIFO_DEPTH - 1);
  localparam logic [31:0] c_tmo_last  = (ARM_TIMEOUT > 0) ? 32'(ARM_TIMEOUT - 1) : 32'd0;

  logic [2:0]  r_state, w_state_nxt;
  logic [15:0] r_dly_hi, r_dly_step;
  logic [7:0]  r_wid_lo, r_wid_hi, r_wid_step, r_mode, r_repeats;
  logic [15:0] r_cur_delay;
  logic [7:0]  r_cur_width, r_rep_cnt;
  logic [31:0] r_word_cnt, r_tmo_cnt, r_attempt_cnt, r_din;
  logic        r_we, r_clr, r_done, r_err;

  logic        w_valid_range, w_accept, w_reject, w_write, w_last_word;
  logic        w_timeout, w_abort, w_rep_more, w_wid_wrap, w_dly_end, w_sweep_end;
  logic [8:0]  w_wid_sum;
  logic [16:0] w_dly_sum;

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_nxt = c_st_fill;
      c_st_fill: if (w_write && w_last_word) w_state_nxt = c_st_arm;
      c_st_arm: begin
        if (!glitch_ready)  w_state_nxt = c_st_run;
        else if (w_timeout) w_state_nxt = c_st_idle;
      end
      c_st_run:  if (glitch_ready) w_state_nxt = c_st_next;
      c_st_next: w_state_nxt = w_sweep_end ? c_st_idle : c_st_fill;
      default:   w_state_nxt = c_st_idle;
    endcase
    if (w_abort) w_state_nxt = c_st_idle;
  end

  // Widened sums make an 8/16-bit carry look like overshooting the upper bound.
  always_comb begin
    busy          = (r_state != c_st_idle);
    w_abort       = abort && busy;
    w_valid_range = (cfg_dly_lo <= cfg_dly_hi) && (cfg_wid_lo <= cfg_wid_hi);
    w_accept      = (r_state == c_st_idle) && start && !abort && w_valid_range;
    w_reject      = (r_state == c_st_idle) && start && !abort && !w_valid_range;
    w_write       = (r_state == c_st_fill) && !fifo_full;
    w_last_word   = (r_word_cnt == c_last_word);
    w_timeout     = glitch_ready && (r_tmo_cnt >= c_tmo_last);
    w_rep_more    = ({1'b0, r_rep_cnt} + 9'd1) < {1'b0, r_repeats};
    w_wid_sum     = {1'b0, r_cur_width} + {1'b0, r_wid_step};
    w_wid_wrap    = w_wid_sum > {1'b0, r_wid_hi};
    w_dly_sum     = {1'b0, r_cur_delay} + {1'b0, r_dly_step};
    w_dly_end     = w_dly_sum > {1'b0, r_dly_hi};
    w_sweep_end   = !w_rep_more && w_wid_wrap && w_dly_end;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_dly_hi      <= 16'd0;
      r_dly_step    <= 16'd0;
      r_wid_lo      <= 8'd0;
      r_wid_hi      <= 8'd0;
      r_wid_step    <= 8'd0;
      r_mode        <= 8'd0;
      r_repeats     <= 8'd0;
      r_cur_delay   <= 16'd0;
      r_cur_width   <= 8'd0;
      r_rep_cnt     <= 8'd0;
      r_word_cnt    <= 32'd0;
      r_tmo_cnt     <= 32'd0;
      r_attempt_cnt <= 32'd0;
      r_din         <= 32'd0;
      r_we          <= 1'b0;
      r_clr         <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_clr  <= 1'b0;
      r_done <= 1'b0;
      if (w_abort) begin
        r_clr <= 1'b1;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (w_accept) begin
              r_dly_hi      <= cfg_dly_hi;
              r_dly_step    <= (cfg_dly_step == 16'd0) ? 16'd1 : cfg_dly_step;
              r_wid_lo      <= cfg_wid_lo;
              r_wid_hi      <= cfg_wid_hi;
              r_wid_step    <= (cfg_wid_step == 8'd0) ? 8'd1 : cfg_wid_step;
              r_mode        <= cfg_mode;
              r_repeats     <= (cfg_repeats == 8'd0) ? 8'd1 : cfg_repeats;
              r_cur_delay   <= cfg_dly_lo;
              r_cur_width   <= cfg_wid_lo;
              r_attempt_cnt <= 32'd0;
              r_err         <= 1'b0;
              r_rep_cnt     <= 8'd0;
              r_word_cnt    <= 32'd0;
            end else if (w_reject) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
          c_st_fill: begin
            if (w_write) begin
              r_we  <= 1'b1;
              r_din <= (r_word_cnt == 32'd0) ? {r_cur_delay, r_cur_width, r_mode}
                                             : {24'h0, r_mode};
              if (w_last_word) begin
                r_word_cnt <= 32'd0;
                r_tmo_cnt  <= 32'd0;
              end else begin
                r_word_cnt <= r_word_cnt + 32'd1;
              end
            end
          end
          c_st_arm: begin
            if (glitch_ready) begin
              if (w_timeout) begin
                r_err <= 1'b1;
                r_clr <= 1'b1;
              end else begin
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
              end
            end
          end
          c_st_run: begin
            if (glitch_ready) r_attempt_cnt <= r_attempt_cnt + 32'd1;
          end
          c_st_next: begin
            if (w_rep_more) begin
              r_rep_cnt <= r_rep_cnt + 8'd1;
            end else begin
              r_rep_cnt <= 8'd0;
              if (!w_wid_wrap) begin
                r_cur_width <= w_wid_sum[7:0];
              end else if (!w_dly_end) begin
                r_cur_width <= r_wid_lo;
                r_cur_delay <= w_dly_sum[15:0];
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fifo_we     = r_we;
  assign fifo_din    = r_din;
  assign fifo_clr    = r_clr;
  assign done        = r_done;
  assign err         = r_err;
  assign cur_delay   = r_cur_delay;
  assign cur_width   = r_cur_width;
  assign attempt_cnt = r_attempt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sweep.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_glitch_sweep                                                |
// | Brief   : Scoreboard bench for glitch_sweep with a small engine model.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_glitch_sweep;
  localparam int FIFO_DEPTH  = 4;
  localparam int ARM_TIMEOUT = 8;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] cfg_dly_lo = '0, cfg_dly_hi = '0, cfg_dly_step = '0;
  logic [7:0]  cfg_wid_lo = '0, cfg_wid_hi = '0, cfg_wid_step = '0;
  logic [7:0]  cfg_mode = '0, cfg_repeats = '0;
  logic        fifo_full = 1'b0, glitch_ready = 1'b1;
  logic        fifo_we, fifo_clr, busy, done, err;
  logic [31:0] fifo_din, attempt_cnt;
  logic [15:0] cur_delay;
  logic [7:0]  cur_width;

  glitch_sweep #(.FIFO_DEPTH(FIFO_DEPTH), .ARM_TIMEOUT(ARM_TIMEOUT)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .abort(abort),
    .cfg_dly_lo(cfg_dly_lo), .cfg_dly_hi(cfg_dly_hi), .cfg_dly_step(cfg_dly_step),
    .cfg_wid_lo(cfg_wid_lo), .cfg_wid_hi(cfg_wid_hi), .cfg_wid_step(cfg_wid_step),
    .cfg_mode(cfg_mode), .cfg_repeats(cfg_repeats),
    .fifo_full(fifo_full), .glitch_ready(glitch_ready),
    .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_clr(fifo_clr),
    .busy(busy), .done(done), .err(err),
    .cur_delay(cur_delay), .cur_width(cur_width), .attempt_cnt(attempt_cnt)
  );

  always #5 clk_in = ~clk_in;

  int          checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  int          wr_cnt = 0, extra_wr = 0, done_cnt = 0, cyc = 0, last_we_cyc = 0;
  int          eng_timer = 0, eng_low = 3;
  bit          eng_en = 1'b1;
  logic        full_at_edge = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk_in) begin
    cyc          <= cyc + 1;
    full_at_edge <= fifo_full;
  end

  // Write monitor plus engine model: after each full schedule the engine goes busy.
  always @(negedge clk_in) begin
    if (full_at_edge) chk("we_while_full", {31'b0, fifo_we}, 32'd0);
    if (fifo_we) begin
      wr_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() > 0) chk("fifo_din", fifo_din, exp_q.pop_front());
      else extra_wr++;
      if (eng_en && (wr_cnt % FIFO_DEPTH == 0)) eng_timer = eng_low;
    end
    if (done) done_cnt++;
    if (eng_timer > 0) begin
      glitch_ready = 1'b0;
      eng_timer--;
    end else begin
      glitch_ready = 1'b1;
    end
  end

  task automatic push_sweep(input int dlo, dhi, dst, wlo, whi, wst, md, rp,
                            output int n_att, output int last_d, output int last_w);
    int ds, ws, rr;
    ds = (dst == 0) ? 1 : dst;
    ws = (wst == 0) ? 1 : wst;
    rr = (rp == 0) ? 1 : rp;
    n_att = 0; last_d = dlo; last_w = wlo;
    for (int d = dlo; d <= dhi; d += ds) begin
      for (int w = wlo; w <= whi; w += ws) begin
        for (int r = 0; r < rr; r++) begin
          exp_q.push_back({d[15:0], w[7:0], md[7:0]});
          for (int p = 1; p < FIFO_DEPTH; p++) exp_q.push_back({24'h0, md[7:0]});
          n_att++;
        end
        last_d = d; last_w = w;
      end
    end
  endtask

  task automatic pulse_start(input int dlo, dhi, dst, wlo, whi, wst, md, rp);
    cfg_dly_lo = dlo[15:0]; cfg_dly_hi = dhi[15:0]; cfg_dly_step = dst[15:0];
    cfg_wid_lo = wlo[7:0];  cfg_wid_hi = whi[7:0];  cfg_wid_step = wst[7:0];
    cfg_mode = md[7:0];     cfg_repeats = rp[7:0];
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic run_sweep(input string tag, input int dlo, dhi, dst, wlo, whi, wst, md, rp,
                           input bit poke);
    int n, ld, lw, wr0;
    wr0 = wr_cnt;
    push_sweep(dlo, dhi, dst, wlo, whi, wst, md, rp, n, ld, lw);
    pulse_start(dlo, dhi, dst, wlo, whi, wst, md, rp);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_cnt_clr"}, attempt_cnt, 32'd0);
    chk({tag, "_err_clr"}, {31'b0, err}, 32'd0);
    if (poke) begin
      @(negedge clk_in);
      pulse_start(0, 100, 7, 0, 200, 9, 8'hEE, 3);
    end
    wait_done({tag, "_done"}, 2000);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_attempts"}, attempt_cnt, n);
    chk({tag, "_cur_delay"}, {16'h0, cur_delay}, ld);
    chk({tag, "_cur_width"}, {24'h0, cur_width}, lw);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    @(negedge clk_in);
    chk({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    chk({tag, "_q_left"}, exp_q.size(), 32'd0);
    chk({tag, "_writes"}, wr_cnt - wr0, n * FIFO_DEPTH);
    chk({tag, "_extra_wr"}, extra_wr, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ld, lw, d0, k;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_outs", {27'b0, fifo_we, fifo_clr, done, err, 1'b0}, 32'd0);
    chk("rst_din", fifo_din, 32'd0);
    chk("rst_cur", {8'h0, cur_delay, cur_width}, 32'd0);
    chk("rst_attempts", attempt_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk_in);

    // T1, T2 (with a start while busy), T3 (back-pressure mid-fill)
    run_sweep("t1", 10, 30, 10, 2, 2, 0, 5, 1, 1'b0);
    run_sweep("t2", 0, 0, 0, 1, 5, 2, 8'hA5, 2, 1'b1);
    fork
      run_sweep("t3", 0, 0, 1, 7, 7, 1, 8'h3C, 1, 1'b0);
      begin
        repeat (1) @(negedge clk_in);
        fifo_full = 1'b1;
        repeat (5) @(negedge clk_in);
        fifo_full = 1'b0;
      end
    join

    // T4: engine never leaves idle -> arm timeout
    eng_en = 1'b0;
    d0 = done_cnt;
    push_sweep(0, 0, 1, 9, 9, 1, 8'h11, 1, n, ld, lw);
    pulse_start(0, 0, 1, 9, 9, 1, 8'h11, 1);
    k = 0;
    while (!fifo_clr && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    chk("t4_clr", {31'b0, fifo_clr}, 32'd1);
    chk("t4_tmo_cycles", cyc - last_we_cyc, ARM_TIMEOUT);
    chk("t4_err", {31'b0, err}, 32'd1);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    @(negedge clk_in);
    chk("t4_clr_1cyc", {31'b0, fifo_clr}, 32'd0);
    chk("t4_no_done", done_cnt - d0, 32'd0);
    chk("t4_err_sticky", {31'b0, err}, 32'd1);
    chk("t4_q_left", exp_q.size(), 32'd0);
    eng_en = 1'b1;

    // T5: abort while the engine is running the second attempt
    eng_low = 20;
    d0 = done_cnt;
    push_sweep(0, 0, 1, 0, 3, 1, 8'h77, 1, n, ld, lw);
    pulse_start(0, 0, 1, 0, 3, 1, 8'h77, 1);
    chk("t5_err_clr", {31'b0, err}, 32'd0);
    k = 0;
    n = 0;
    while (n < 8 && k < 500) begin
      if (fifo_we) n++;
      if (n < 8) @(negedge clk_in);
      k++;
    end
    chk("t5_writes", n, 32'd8);
    repeat (2) @(negedge clk_in);
    abort = 1'b1;
    @(negedge clk_in);
    abort = 1'b0;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_clr", {31'b0, fifo_clr}, 32'd1);
    chk("t5_we", {31'b0, fifo_we}, 32'd0);
    chk("t5_attempts", attempt_cnt, 32'd1);
    chk("t5_err", {31'b0, err}, 32'd0);
    @(negedge clk_in);
    chk("t5_clr_1cyc", {31'b0, fifo_clr}, 32'd0);
    exp_q.delete();
    eng_low = 3;
    repeat (25) @(negedge clk_in);
    chk("t5_no_done", done_cnt - d0, 32'd0);
    run_sweep("t5r", 0, 0, 1, 0, 1, 1, 8'h77, 1, 1'b0);

    // T6: delay carry ends sweep; invalid start; start+abort in idle
    run_sweep("t6", 16'h8000, 16'hFFFF, 16'h8000, 3, 4, 1, 8'h42, 1, 1'b0);
    pulse_start(0, 0, 1, 5, 4, 1, 0, 1);
    chk("t6_inv_done", {31'b0, done}, 32'd1);
    chk("t6_inv_err", {31'b0, err}, 32'd1);
    chk("t6_inv_busy", {31'b0, busy}, 32'd0);
    @(negedge clk_in);
    chk("t6_inv_done_1cyc", {31'b0, done}, 32'd0);
    abort = 1'b1;
    pulse_start(0, 0, 1, 0, 0, 1, 0, 1);
    abort = 1'b0;
    chk("t6_abort_wins", {30'b0, busy, done}, 32'd0);
    chk("t6_abort_err", {31'b0, err}, 32'd1);
    repeat (3) @(negedge clk_in);
    chk("t6_extra_wr", extra_wr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
